// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - Scrolled raster to 20x20 tile ROM address and level-map row/column generator
module tile_addr_gen #(
  parameter int TILE     = 20,
  parameter int MAP_COLS = 128,
  parameter int COL_W    = 7,
  parameter int SCROLL_W = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic [SCROLL_W-1:0] scroll_x,
  input  logic                line_start,
  input  logic                pix_en,
  output logic [8:0]          read_address,
  output logic [COL_W-1:0]    tile_col,
  output logic [4:0]          tile_row,
  output logic                addr_valid,
  output logic                busy
);

  localparam int PX_W = $clog2(TILE);

  typedef enum logic [1:0] {IDLE, DIV, READY} state_t;

  state_t state, state_nxt;

  logic [SCROLL_W-1:0] rem;
  logic [COL_W-1:0]    quot;
  logic [PX_W-1:0]     scroll_px;
  logic [COL_W-1:0]    scroll_tile;

  logic [PX_W-1:0]     px;
  logic [4:0]          py;
  logic [COL_W-1:0]    col;
  logic [4:0]          row;
  logic [8:0]          row_base;
  logic                first_line;

  logic                rem_ge_tile;
  logic [PX_W-1:0]     cur_px;
  logic [COL_W-1:0]    cur_col;
  logic [4:0]          cur_py;
  logic [4:0]          cur_row;
  logic [8:0]          cur_row_base;

  assign rem_ge_tile = (rem >= SCROLL_W'(TILE));

  // State register for the per-frame scroll decomposition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: frame_start always (re)starts division; DIV ends when remainder drops below TILE
  always_comb begin
    state_nxt = state;
    if (frame_start)                     state_nxt = DIV;
    else if (state == DIV && !rem_ge_tile) state_nxt = READY;
  end

  // FSM outputs
  always_comb begin
    busy = (state == DIV);
  end

  // Line-start view of the counters, so a pixel arriving with line_start uses the fresh values
  always_comb begin
    cur_px       = px;
    cur_col      = col;
    cur_py       = py;
    cur_row      = row;
    cur_row_base = row_base;
    if (line_start) begin
      cur_px  = scroll_px;
      cur_col = scroll_tile;
      if (!first_line) begin
        if (py == 5'(TILE - 1)) begin
          cur_py       = '0;
          cur_row_base = '0;
          cur_row      = (row == 5'd31) ? row : row + 5'd1;
        end else begin
          cur_py       = py + 5'd1;
          cur_row_base = row_base + 9'(TILE);
        end
      end
    end
  end

  // Scroll decomposition, raster counters and registered ROM address outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem          <= '0;
      quot         <= '0;
      scroll_px    <= '0;
      scroll_tile  <= '0;
      px           <= '0;
      py           <= '0;
      col          <= '0;
      row          <= '0;
      row_base     <= '0;
      first_line   <= 1'b1;
      read_address <= '0;
      tile_col     <= '0;
      tile_row     <= '0;
      addr_valid   <= 1'b0;
    end else begin
      addr_valid <= 1'b0;
      if (frame_start) begin
        rem        <= scroll_x;
        quot       <= '0;
        first_line <= 1'b1;
        py         <= '0;
        row        <= '0;
        row_base   <= '0;
      end else if (state == DIV) begin
        // Quotient is kept modulo MAP_COLS as it counts, so no final modulo is needed
        if (rem_ge_tile) begin
          rem  <= rem - SCROLL_W'(TILE);
          quot <= (quot == COL_W'(MAP_COLS - 1)) ? '0 : quot + 1'b1;
        end else begin
          scroll_px   <= rem[PX_W-1:0];
          scroll_tile <= quot;
        end
      end else begin
        if (line_start) begin
          first_line <= 1'b0;
          py         <= cur_py;
          row        <= cur_row;
          row_base   <= cur_row_base;
          px         <= cur_px;
          col        <= cur_col;
        end
        if (pix_en) begin
          read_address <= cur_row_base + 9'(cur_px);
          tile_col     <= cur_col;
          tile_row     <= cur_row;
          addr_valid   <= 1'b1;
          if (cur_px == PX_W'(TILE - 1)) begin
            px  <= '0;
            col <= (cur_col == COL_W'(MAP_COLS - 1)) ? '0 : cur_col + 1'b1;
          end else begin
            px  <= cur_px + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// tb/tb_tile_addr_gen.sv - Directed self-checking bench for tile_addr_gen
module tb_tile_addr_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] scroll_x = '0;
  logic        line_start = 1'b0;
  logic        pix_en = 1'b0;
  logic [8:0]  read_address;
  logic [6:0]  tile_col;
  logic [4:0]  tile_row;
  logic        addr_valid;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  tile_addr_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .scroll_x     (scroll_x),
    .line_start   (line_start),
    .pix_en       (pix_en),
    .read_address (read_address),
    .tile_col     (tile_col),
    .tile_row     (tile_row),
    .addr_valid   (addr_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse frame_start and count how many cycles busy stays high afterwards
  task automatic do_frame(input logic [11:0] sx, output int n);
    scroll_x    = sx;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic pix(input logic ls);
    line_start = ls;
    pix_en     = 1'b1;
    tick();
    line_start = 1'b0;
    pix_en     = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    compared++;
    if ({read_address, tile_col, tile_row, addr_valid, busy} !== 23'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected 0", {read_address, tile_col, tile_row, addr_valid, busy});
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_scroll();
    int n;
    do_frame(12'd0, n);
    compared++;
    if (n !== 1) begin mismatched++; $display("FAIL zero_busy_cycles: got %0d expected 1", n); end
    for (int i = 0; i < 25; i++) begin
      pix(i == 0);
      compared++;
      if (addr_valid !== 1'b1 || read_address !== 9'(i % 20) || tile_col !== 7'(i / 20) || tile_row !== 5'd0) begin
        mismatched++;
        $display("FAIL zero_pix%0d: got v=%0d a=%0d c=%0d r=%0d expected v=1 a=%0d c=%0d r=0",
                 i, addr_valid, read_address, tile_col, tile_row, i % 20, i / 20);
      end
    end
    tick();
    compared++;
    if (addr_valid !== 1'b0 || read_address !== 9'd4 || tile_col !== 7'd1) begin
      mismatched++;
      $display("FAIL zero_idle_hold: got v=%0d a=%0d c=%0d expected v=0 a=4 c=1", addr_valid, read_address, tile_col);
    end
  endtask

  task automatic test_scroll_decompose();
    int n;
    int ea, ec;
    do_frame(12'd47, n);
    compared++;
    if (n !== 3) begin mismatched++; $display("FAIL s47_busy_cycles: got %0d expected 3", n); end
    for (int i = 0; i < 20; i++) begin
      pix(i == 0);
      ea = (i < 13) ? 7 + i : i - 13;
      ec = (i < 13) ? 2 : 3;
      compared++;
      if (addr_valid !== 1'b1 || read_address !== 9'(ea) || tile_col !== 7'(ec) || tile_row !== 5'd0) begin
        mismatched++;
        $display("FAIL s47_pix%0d: got v=%0d a=%0d c=%0d r=%0d expected v=1 a=%0d c=%0d r=0",
                 i, addr_valid, read_address, tile_col, tile_row, ea, ec);
      end
    end
  endtask

  task automatic test_row_advance();
    int n;
    int ea, er;
    do_frame(12'd0, n);
    for (int l = 0; l < 21; l++) begin
      pix(1'b1);
      tick();
      ea = (l < 20) ? 20 * l : 0;
      er = (l < 20) ? 0 : 1;
      compared++;
      if (read_address !== 9'(ea) || tile_row !== 5'(er) || tile_col !== 7'd0) begin
        mismatched++;
        $display("FAIL row_line%0d: got a=%0d r=%0d c=%0d expected a=%0d r=%0d c=0",
                 l, read_address, tile_row, tile_col, ea, er);
      end
    end
  endtask

  task automatic test_col_wrap();
    int n;
    int ec;
    do_frame(12'd2540, n);
    compared++;
    if (n !== 128) begin mismatched++; $display("FAIL wrap_busy_cycles: got %0d expected 128", n); end
    for (int i = 0; i < 25; i++) begin
      pix(i == 0);
      ec = (i < 20) ? 127 : 0;
      compared++;
      if (read_address !== 9'(i % 20) || tile_col !== 7'(ec)) begin
        mismatched++;
        $display("FAIL wrap_pix%0d: got a=%0d c=%0d expected a=%0d c=%0d", i, read_address, tile_col, i % 20, ec);
      end
    end
  endtask

  task automatic test_restart_ignore();
    int n;
    scroll_x    = 12'd4095;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      line_start = (i == 0);
      pix_en     = 1'b1;
      tick();
      compared++;
      if (addr_valid !== 1'b0 || busy !== 1'b1) begin
        mismatched++;
        $display("FAIL busy_ignore%0d: got v=%0d busy=%0d expected v=0 busy=1", i, addr_valid, busy);
      end
    end
    line_start = 1'b0;
    pix_en     = 1'b0;
    do_frame(12'd40, n);
    compared++;
    if (n !== 3) begin mismatched++; $display("FAIL restart_busy_cycles: got %0d expected 3", n); end
    pix(1'b1);
    compared++;
    if (addr_valid !== 1'b1 || read_address !== 9'd0 || tile_col !== 7'd2 || tile_row !== 5'd0) begin
      mismatched++;
      $display("FAIL restart_pix: got v=%0d a=%0d c=%0d r=%0d expected v=1 a=0 c=2 r=0",
               addr_valid, read_address, tile_col, tile_row);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_frame(12'd47, n);
    for (int i = 0; i < 5; i++) begin
      line_start = (i == 0);
      pix_en     = 1'b1;
      tick();
    end
    line_start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({read_address, tile_col, tile_row, addr_valid, busy} !== 23'd0) begin
      mismatched++;
      $display("FAIL async_reset_midline: got a=%0d c=%0d r=%0d v=%0d b=%0d expected all 0",
               read_address, tile_col, tile_row, addr_valid, busy);
    end
    pix_en = 1'b0;
    tick();
    reset_n = 1'b1;
    scroll_x    = 12'd4095;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL async_reset_busy: got %0d expected 0", busy); end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_scroll();
    test_scroll_decompose();
    test_row_advance();
    test_col_wrap();
    test_restart_ignore();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
